immediate_encoder: RTL and testbench

IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

---
 rtl/immediate_encoder.sv | 109 ++++++++++
 tb/tb_immediate_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_encoder.sv
// Packs a two's-complement immediate into instruction bits [31:7] for the
// I/S/B/U/J formats, behind a single ready/valid output register stage.
module immediate_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [2:0]  immSrc,
    input  logic [31:0] imm,
    input  logic [24:0] base,
    output logic        outValid,
    input  logic        outReady,
    output logic [24:0] out,
    output logic        err,
    output logic [7:0]  errCount,
    output logic [15:0] encCount
);

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_U = 3'b011,
        FMT_J = 3'b100
    } fmt_t;

    fmt_t        fmt;
    logic        accept;
    logic        deliver;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;
    logic [24:0] enc_bits;
    logic        enc_err;

    assign fmt     = fmt_t'(immSrc);
    assign inReady = !outValid || outReady;
    assign accept  = inValid && inReady;
    assign deliver = outValid && outReady;

    // Upper bits must be pure sign extension of the top encodable bit.
    assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        enc_bits = base;
        enc_err  = 1'b0;
        case (fmt)
            FMT_I: begin
                enc_err         = !fits_12;
                enc_bits[24:13] = imm[11:0];
            end
            FMT_S: begin
                enc_err         = !fits_12;
                enc_bits[24:18] = imm[11:5];
                enc_bits[4:0]   = imm[4:0];
            end
            FMT_B: begin
                enc_err         = !fits_13 || imm[0];
                enc_bits[24]    = imm[12];
                enc_bits[23:18] = imm[10:5];
                enc_bits[4:1]   = imm[4:1];
                enc_bits[0]     = imm[11];
            end
            FMT_U: begin
                enc_err        = |imm[11:0];
                enc_bits[24:5] = imm[31:12];
            end
            FMT_J: begin
                enc_err         = !fits_21 || imm[0];
                enc_bits[24]    = imm[20];
                enc_bits[23:14] = imm[10:1];
                enc_bits[13]    = imm[11];
                enc_bits[12:5]  = imm[19:12];
            end
            default: enc_err = 1'b1;
        endcase
        // Unencodable requests pass the non-immediate fields through untouched.
        if (enc_err) begin
            enc_bits = base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid <= 1'b0;
            out      <= '0;
            err      <= 1'b0;
            errCount <= '0;
            encCount <= '0;
        end else begin
            if (deliver) begin
                encCount <= encCount + 16'd1;
                if (err && errCount != 8'hFF) begin
                    errCount <= errCount + 8'd1;
                end
            end
            if (accept) begin
                outValid <= 1'b1;
                out      <= enc_bits;
                err      <= enc_err;
            end else if (deliver) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_immediate_encoder.sv
// Randomized and directed bench for immediate_encoder, checked against a
// range-based reference model and the immediate extender (round-trip).
module tb_immediate_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [2:0]  immSrc;
    logic [31:0] imm;
    logic [24:0] base;
    logic        outValid;
    logic        outReady;
    logic [24:0] out;
    logic        err;
    logic [7:0]  errCount;
    logic [15:0] encCount;

    immediate_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inReady  (inReady),
        .immSrc   (immSrc),
        .imm      (imm),
        .base     (base),
        .outValid (outValid),
        .outReady (outReady),
        .out      (out),
        .err      (err),
        .errCount (errCount),
        .encCount (encCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [24:0] base;
        bit          has_exp;
        logic [24:0] exp_out;
        bit          exp_err;
    } req_t;

    req_t        q[$];
    req_t        cur;
    logic [15:0] exp_enc = '0;
    logic [7:0]  exp_errc = '0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Encodability from the signed value range of each format.
    function automatic bit model_err(input logic [2:0] f, input logic [31:0] v);
        int s;
        s = $signed(v);
        case (f)
            3'd0, 3'd1: return !(s >= -2048 && s <= 2047);
            3'd2:       return !(s >= -4096 && s <= 4095) || (v % 32'd2 != 0);
            3'd3:       return (v % 32'd4096) != 0;
            3'd4:       return !(s >= -(1 << 20) && s < (1 << 20)) || (v % 32'd2 != 0);
            default:    return 1'b1;
        endcase
    endfunction

    // Immediate extender: recovers the immediate from packed bits [31:7].
    function automatic logic [31:0] extend(input logic [2:0] f, input logic [24:0] o);
        case (f)
            3'd0:    return {{20{o[24]}}, o[24:13]};
            3'd1:    return {{20{o[24]}}, o[24:18], o[4:0]};
            3'd2:    return {{19{o[24]}}, o[24], o[0], o[23:18], o[4:1], 1'b0};
            3'd3:    return {o[24:5], 12'b0};
            default: return {{11{o[24]}}, o[24], o[12:5], o[13], o[23:14], 1'b0};
        endcase
    endfunction

    function automatic logic [24:0] keep(input logic [2:0] f);
        case (f)
            3'd0:       return 25'h0001FFF;
            3'd1, 3'd2: return 25'h003FFE0;
            default:    return 25'h000001F;
        endcase
    endfunction

    task automatic check_item(input req_t r);
        bit e;
        e = model_err(r.fmt, r.imm);
        check("err", 32'(err), 32'(e));
        if (e) begin
            check("out_eq_base", 32'(out), 32'(r.base));
        end else begin
            check("imm_roundtrip", extend(r.fmt, out), r.imm);
            check("base_fields", 32'(out & keep(r.fmt)), 32'(r.base & keep(r.fmt)));
        end
        if (r.has_exp) begin
            check("dir_out", 32'(out), 32'(r.exp_out));
            check("dir_err", 32'(err), 32'(r.exp_err));
        end
    endtask

    // One clock cycle with inputs already applied; model advances at the edge.
    task automatic step();
        bit   model_ready;
        req_t r;
        @(negedge clk);
        model_ready = (q.size() == 0) || outReady;
        check("in_ready", 32'(inReady), 32'(model_ready));
        check("out_valid", 32'(outValid), 32'(q.size() != 0));
        if (q.size() != 0) check_item(q[0]);
        if (rst) begin
            @(posedge clk); #1;
            q.delete();
            exp_enc  = '0;
            exp_errc = '0;
            check("rst_out", 32'(out), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_valid", 32'(outValid), 32'd0);
        end else begin
            if (q.size() != 0 && outReady) begin
                r = q.pop_front();
                exp_enc = exp_enc + 16'd1;
                if (model_err(r.fmt, r.imm) && exp_errc != 8'hFF) exp_errc = exp_errc + 8'd1;
            end
            if (inValid && model_ready) q.push_back(cur);
            @(posedge clk); #1;
        end
        check("enc_count", 32'(encCount), 32'(exp_enc));
        check("err_count", 32'(errCount), 32'(exp_errc));
    endtask

    task automatic drive(input bit v, input logic [2:0] f, input logic [31:0] i,
                         input logic [24:0] b, input bit rdy, input bit he = 1'b0,
                         input logic [24:0] eo = '0, input bit ee = 1'b0);
        inValid  = v;
        immSrc   = f;
        imm      = i;
        base     = b;
        outReady = rdy;
        cur.fmt = f; cur.imm = i; cur.base = b;
        cur.has_exp = he; cur.exp_out = eo; cur.exp_err = ee;
        step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) drive(1'b0, 3'd0, '0, '0, 1'b1);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return r;
            1:       return {{20{r[11]}}, r[11:0]};
            2:       return {{19{r[12]}}, r[12:1], 1'b0};
            3:       return r & 32'hFFFFF000;
            4:       return {{11{r[20]}}, r[20:1], 1'b0};
            default: return {{19{r[12]}}, r[12:0]};
        endcase
    endfunction

    initial begin
        rst = 1'b1; inValid = 1'b0; immSrc = '0; imm = '0; base = '0; outReady = 1'b1;
        do_reset(2);

        // Known encodings
        drive(1'b1, 3'd0, 32'hFFFFFFFF, 25'h0, 1'b1, 1'b1, 25'h1FFE000, 1'b0);
        drive(1'b1, 3'd2, 32'h00000800, 25'h0, 1'b1, 1'b1, 25'h0000001, 1'b0);
        drive(1'b1, 3'd2, 32'h00000003, 25'h0ABCDEF, 1'b1, 1'b1, 25'h0ABCDEF, 1'b1);
        drive(1'b1, 3'd3, 32'h12345000, 25'h000001F, 1'b1, 1'b1, 25'h02468BF, 1'b0);
        drive(1'b1, 3'd3, 32'h00000001, 25'h1234567, 1'b1, 1'b1, 25'h1234567, 1'b1);
        drive(1'b0, 3'd0, '0, '0, 1'b1);

        do_reset(1);
        drive(1'b1, 3'd4, 32'h00100000, 25'h0055555, 1'b1, 1'b1, 25'h0055555, 1'b1);
        drive(1'b1, 3'd7, 32'h00000000, 25'h1AAAAAA, 1'b1, 1'b1, 25'h1AAAAAA, 1'b1);
        drive(1'b0, 3'd0, '0, '0, 1'b1);
        check("err_count_two", 32'(errCount), 32'd2);

        // Backpressure, then back-to-back drain
        for (int unsigned k = 0; k < 4; k++)
            drive(1'b1, 3'd0, 32'(k) + 32'd5, 25'(k) + 25'h100, 1'b0);
        check("bp_in_ready", 32'(inReady), 32'd0);
        for (int unsigned k = 0; k < 4; k++)
            drive(1'b1, 3'd1, 32'(k) * 32'd3, 25'h1F00000, 1'b1);
        drive(1'b0, 3'd0, '0, '0, 1'b1);

        // Reset with a pending result
        drive(1'b1, 3'd3, 32'hABCDE000, 25'h1F, 1'b0);
        drive(1'b1, 3'd0, 32'h00000010, 25'h0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        rst = 1'b0;
        check("ready_after_rst", 32'(inReady), 32'd1);
        repeat (3) drive(1'b0, 3'd0, '0, '0, 1'b1);

        // Random traffic
        for (int unsigned k = 0; k < 3000; k++)
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_imm(),
                  25'($urandom), ($urandom_range(0, 3) != 0));
        drive(1'b0, 3'd0, '0, '0, 1'b1);

        // errCount saturation
        do_reset(1);
        for (int unsigned k = 0; k < 260; k++)
            drive(1'b1, 3'($urandom_range(5, 7)), $urandom, 25'($urandom), 1'b1);
        drive(1'b0, 3'd0, '0, '0, 1'b1);
        check("err_count_sat", 32'(errCount), 32'd255);
        check("enc_count_260", 32'(encCount), 32'd260);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
